// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Single-cycle opcodes produce a result on the edge after accept; opcode 0111
// runs a shift-add multiply over WIDTH steps and finishes on the next edge.
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_PASS_B = 4'b0010;
  localparam logic [3:0] OP_ADD    = 4'b0011;
  localparam logic [3:0] OP_NAND   = 4'b0100;
  localparam logic [3:0] OP_SHL    = 4'b0101;
  localparam logic [3:0] OP_SHR    = 4'b0110;
  localparam logic [3:0] OP_MUL    = 4'b0111;

  // Result pattern for undefined opcodes: ones on even bit positions.
  localparam logic [63:0]      ALT64 = {16{4'h5}};
  localparam logic [WIDTH-1:0] ALT   = ALT64[WIDTH-1:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             armed_q;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept_c;
  logic             is_mul_c;
  logic             mul_last_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   dif_c;
  logic [WIDTH-1:0] alu_s_c;
  logic             alu_carry_c;
  logic             alu_ovf_c;

  assign accept_c   = in_valid && in_ready;
  assign is_mul_c   = (f == OP_MUL);
  assign mul_last_c = (cnt_q == CNT_W'(WIDTH));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = is_mul_c ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (mul_last_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (accept_c)       state_d = is_mul_c ? ST_BUSY : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; ready is withheld until the first edge after reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = armed_q;
      ST_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Single-cycle ALU result and flags from the live request inputs.
  always_comb begin
    sum_c       = {1'b0, a} + {1'b0, b};
    dif_c       = {1'b0, a} - {1'b0, b};
    alu_s_c     = '0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    case (f)
      OP_PASS_A: alu_s_c = a;
      OP_SUB: begin
        alu_s_c     = dif_c[WIDTH-1:0];
        alu_carry_c = dif_c[WIDTH];
        alu_ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_PASS_B: alu_s_c = b;
      OP_ADD: begin
        alu_s_c     = sum_c[WIDTH-1:0];
        alu_carry_c = sum_c[WIDTH];
        alu_ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NAND: alu_s_c = ~(a & b);
      OP_SHL: begin
        alu_s_c     = {a[WIDTH-2:0], 1'b0};
        alu_carry_c = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_s_c     = {1'b0, a[WIDTH-1:1]};
        alu_carry_c = a[0];
      end
      OP_MUL: alu_s_c = '0;
      default: begin
        alu_s_c     = ALT;
        alu_carry_c = 1'b1;
      end
    endcase
  end

  // Datapath next values: capture on accept, step the multiplier in BUSY, load result on finish.
  always_comb begin
    s_d      = s_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (accept_c) begin
      if (is_mul_c) begin
        acc_d    = '0;
        mcand_d  = PW'(a);
        mplier_d = b;
        cnt_d    = '0;
      end else begin
        s_d     = alu_s_c;
        carry_d = alu_carry_c;
        ovf_d   = alu_ovf_c;
      end
    end else if (state_q == ST_BUSY) begin
      if (mul_last_c) begin
        s_d     = acc_q[WIDTH-1:0];
        carry_d = |acc_q[PW-1:WIDTH];
        ovf_d   = 1'b0;
      end else begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers; reset discards any multiply in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q  <= 1'b0;
      s_q      <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      armed_q  <= 1'b1;
      s_q      <= s_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s     = s_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign zero  = (s_q == '0);
  assign neg   = s_q[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=4 instance for most vectors and a
// WIDTH=8 instance for the wide-pattern and wide-multiply cases.
module tb_alu_seq;

  logic       clk;
  logic       reset;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] f, a, b, s;
  logic       carry, zero, neg, ovf;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0] f8;
  logic [7:0] a8, b8, s8;
  logic       carry8, zero8, neg8, ovf8;

  int n_checks;
  int n_fail;

  alu_seq #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .f(f), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .f(f8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .carry(carry8), .zero(zero8), .neg(neg8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request for a single edge (WIDTH=4 instance).
  task automatic op(input logic [3:0] fi, input logic [3:0] ai, input logic [3:0] bi);
    @(negedge clk);
    in_valid = 1'b1;
    f = fi;
    a = ai;
    b = bi;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic op8(input logic [3:0] fi, input logic [7:0] ai, input logic [7:0] bi);
    @(negedge clk);
    in_valid8 = 1'b1;
    f8 = fi;
    a8 = ai;
    b8 = bi;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  // Directed single-cycle vectors: f, a, b, expected s, carry, ovf.
  logic [3:0] tv_f [7] = '{4'h2, 4'h4, 4'h5, 4'h6, 4'hF, 4'h1, 4'h3};
  logic [3:0] tv_a [7] = '{4'h3, 4'hC, 4'h9, 4'h9, 4'h0, 4'h8, 4'h9};
  logic [3:0] tv_b [7] = '{4'hA, 4'hA, 4'h0, 4'h0, 4'h0, 4'h1, 4'h9};
  logic [3:0] tv_s [7] = '{4'hA, 4'h7, 4'h2, 4'h4, 4'h5, 4'h7, 4'h2};
  logic       tv_c [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       tv_o [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int  edges;
    bit  seen;
    bit  busy_ready;

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0; out_ready  = 1'b1; f  = '0; a  = '0; b  = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; f8 = '0; a8 = '0; b8 = '0;

    // Reset values while reset is held low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(in_ready), 32'd1);

    // Add with carry out and zero result.
    op(4'h3, 4'hF, 4'h1);
    check("add_ff_valid", 32'(out_valid), 32'd1);
    check("add_ff_s", 32'(s), 32'h0);
    check("add_ff_carry", 32'(carry), 32'd1);
    check("add_ff_zero", 32'(zero), 32'd1);
    check("add_ff_ovf", 32'(ovf), 32'd0);

    // Consumer takes it with no new request: back to idle, result held.
    @(posedge clk);
    #1;
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_s_hold", 32'(s), 32'h0);
    check("idle_ready", 32'(in_ready), 32'd1);

    // Subtract with borrow.
    op(4'h1, 4'h3, 4'h5);
    check("sub_s", 32'(s), 32'hE);
    check("sub_carry", 32'(carry), 32'd1);
    check("sub_neg", 32'(neg), 32'd1);
    check("sub_zero", 32'(zero), 32'd0);
    check("sub_ovf", 32'(ovf), 32'd0);

    // Back-to-back add with signed overflow.
    op(4'h3, 4'h7, 4'h1);
    check("add_ovf_valid", 32'(out_valid), 32'd1);
    check("add_ovf_s", 32'(s), 32'h8);
    check("add_ovf_ovf", 32'(ovf), 32'd1);
    check("add_ovf_neg", 32'(neg), 32'd1);
    check("add_ovf_carry", 32'(carry), 32'd0);

    // Stall: result held for three cycles while a new request waits.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    f = 4'h0; a = 4'h9; b = 4'h0;
    #1;
    check("stall_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_s", 32'(s), 32'h8);
      check("stall_ovf", 32'(ovf), 32'd1);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release_s", 32'(s), 32'h9);
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_ovf", 32'(ovf), 32'd0);

    // Remaining single-cycle opcodes, issued back to back.
    for (int i = 0; i < 7; i++) begin
      op(tv_f[i], tv_a[i], tv_b[i]);
      check($sformatf("vec%0d_s", i), 32'(s), 32'(tv_s[i]));
      check($sformatf("vec%0d_carry", i), 32'(carry), 32'(tv_c[i]));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(tv_o[i]));
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(tv_s[i] == 4'h0));
      check($sformatf("vec%0d_neg", i), 32'(neg), 32'(tv_s[i][3]));
    end

    // Multiply 7*3 = 0x15: low nibble 5, upper nonzero; busy-time requests ignored.
    op(4'h7, 4'h7, 4'h3);
    check("mul_accept_valid", 32'(out_valid), 32'd0);
    check("mul_accept_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    f = 4'h0; a = 4'hF; b = 4'h0;
    edges = 0;
    busy_ready = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      edges = e;
      if (out_valid) break;
      if (in_ready) busy_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("mul_latency", 32'(edges), 32'd5);
    check("mul_busy_ready", 32'(busy_ready), 32'd0);
    check("mul_s", 32'(s), 32'h5);
    check("mul_carry", 32'(carry), 32'd1);
    check("mul_ovf", 32'(ovf), 32'd0);

    // Reset in the middle of a multiply.
    op(4'h7, 4'h3, 4'h3);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_s", 32'(s), 32'd0);
    check("midrst_zero", 32'(zero), 32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    check("midrst_s_after", 32'(s), 32'd0);

    // Wide instance: undefined opcode pattern and multiplies.
    op8(4'hA, 8'h12, 8'h34);
    check("w8_undef_s", 32'(s8), 32'h55);
    check("w8_undef_carry", 32'(carry8), 32'd1);
    check("w8_undef_zero", 32'(zero8), 32'd0);

    op8(4'h7, 8'h0F, 8'h11);
    edges = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      edges = e;
      if (out_valid8) break;
    end
    check("w8_mul_latency", 32'(edges), 32'd9);
    check("w8_mul_s", 32'(s8), 32'hFF);
    check("w8_mul_carry", 32'(carry8), 32'd0);
    check("w8_mul_neg", 32'(neg8), 32'd1);

    op8(4'h7, 8'h10, 8'h10);
    edges = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      edges = e;
      if (out_valid8) break;
    end
    check("w8_mul2_latency", 32'(edges), 32'd9);
    check("w8_mul2_s", 32'(s8), 32'h00);
    check("w8_mul2_carry", 32'(carry8), 32'd1);
    check("w8_mul2_zero", 32'(zero8), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 f  input  4  opcode.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 s  output  WIDTH  registered result.
REQ-012 carry  output  1  registered carry/borrow/overflow-out flag.
REQ-013 zero  output  1  registered flag, 1 when s is all zeros.
REQ-014 neg  output  1  registered flag, copy of s[WIDTH-1].
REQ-015 ovf  output  1  registered signed-overflow flag.

Function
REQ-016 Request accepted on a rising edge where in_valid and in_ready are both 1; a, b, f captured at that edge.
REQ-017 FSM states IDLE, BUSY, DONE; in_ready = 1 in IDLE, or in DONE with out_ready = 1, else 0.
REQ-018 Opcodes: 0000 s=a; 0001 s=a-b; 0010 s=b; 0011 s=a+b; 0100 s=~(a&b); 0101 s=a<<1; 0110 s=a>>1 (logical); 0111 s=low WIDTH bits of a*b.
REQ-019 Single-cycle opcodes (all except 0111): accept in IDLE/DONE -> DONE, out_valid = 1 on the edge following accept.
REQ-020 Opcode 0111: accept -> BUSY; shift-add multiply, one partial-product step per cycle, WIDTH steps; BUSY -> DONE after WIDTH cycles, so out_valid rises WIDTH+1 edges after accept.
REQ-021 DONE with out_ready = 1 and no new accept -> IDLE, out_valid = 0 next cycle.
REQ-022 DONE with out_ready = 0 -> hold s and all flags unchanged; in_ready = 0.
REQ-023 DONE with out_ready = 1 and in_valid = 1 -> new request accepted same edge (back-to-back, one result per cycle for single-cycle ops).
REQ-024 Carry: add = bit WIDTH of (WIDTH+1)-bit sum; sub = 1 when a < b unsigned (borrow); shl = a[WIDTH-1]; shr = a[0]; mul = 1 when upper WIDTH bits of the 2*WIDTH product are nonzero; pass and nand = 0.
REQ-025 Ovf: add/sub = two's-complement signed overflow; all other opcodes = 0.
REQ-026 Opcodes 1000-1111 (undefined): single-cycle; s bit i = 1 for even i, 0 for odd i (4'b0101 at WIDTH=4); carry = 1; ovf = 0; zero/neg from s.
REQ-027 zero and neg always derived from the registered s.
REQ-028 s and flags change only on the edge that sets out_valid; otherwise hold last values.
REQ-029 in_valid while BUSY is ignored (not captured, not queued).

Reset
REQ-030 reset = 0 forces, asynchronously, state IDLE, s = 0, carry = 0, zero = 1, neg = 0, ovf = 0, out_valid = 0, in_ready = 0 while asserted.
REQ-031 After reset deassertion, in_ready = 1 from the first clock edge onward.
REQ-032 Reset during BUSY aborts the multiply; partial product discarded; no result emitted.

Verification
REQ-033 WIDTH=4, f=0011, a=F, b=1, out_ready=1 -> next cycle out_valid=1, s=0, carry=1, zero=1, ovf=0.
REQ-034 WIDTH=4, f=0001, a=3, b=5 -> s=E, carry=1, neg=1, zero=0, ovf=0; f=0011, a=7, b=1 -> s=8, ovf=1, neg=1.
REQ-035 WIDTH=4, f=0111, a=7, b=3 -> in_ready=0 for 4 cycles, out_valid on 5th edge after accept, s=5, carry=1.
REQ-036 Result held with out_ready=0 for 3 cycles -> s/flags stable, in_ready=0; out_ready=1 with in_valid=1 -> next op accepted same edge.
REQ-037 WIDTH=4, f=1111 -> s=5, carry=1, zero=0; WIDTH=8, f=1010 -> s=55.
REQ-038 reset pulsed low mid-multiply -> outputs at reset values immediately; no out_valid after release until a new accept.
